x25519_operand_loader: RTL

Upstream front end for the X25519 scalar multiplier. Accepts the 256-bit scalar and u-coordinate as eight 32-bit little-endian words each over a valid/ready bus, and applies RFC 7748 clamping and masking. Once both operands are loaded and the host requests a start, it launches the multiplier with a one-cycle `mult_en` pulse. It holds the operands stable until `mult_out_valid` returns, then reports completion.

---
 rtl/x25519_pkg.sv | 38 +++
 rtl/x25519_operand_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/x25519_pkg.sv
// x25519_pkg
//   Shared definitions for the X25519 operand loader and its bench:
//   operand geometry, loader state encoding and the RFC 7748 scalar
//   clamp / u-coordinate mask helpers.
package x25519_pkg;

  localparam int unsigned X25519_WORDS     = 8;
  localparam int unsigned X25519_WORD_BITS = 32;
  localparam int unsigned X25519_BITS      = X25519_WORDS * X25519_WORD_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

  // Scalar clamp: clear the cofactor bits 2:0, clear bit 255, set bit 254.
  function automatic logic [X25519_BITS-1:0] x25519_clamp_scalar(
    input logic [X25519_BITS-1:0] k
  );
    logic [X25519_BITS-1:0] r;
    r      = k;
    r[2:0] = '0;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

  // u-coordinate mask: the top bit is ignored by X25519.
  function automatic logic [X25519_BITS-1:0] x25519_mask_u(
    input logic [X25519_BITS-1:0] u
  );
    logic [X25519_BITS-1:0] r;
    r      = u;
    r[255] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/x25519_operand_loader.sv
// x25519_operand_loader
//   Front end for the X25519 scalar multiplier. Collects the scalar and
//   u-coordinate as eight 32-bit little-endian words each, clamps/masks
//   them in place on the final word, and launches the multiplier with a
//   one-cycle mult_en pulse once both are loaded and start is requested.
//   Operands are held until mult_out_valid returns, then done pulses.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   din_valid/ready word handshake (ready only while idle)
//   din_sel         0 = scalar, 1 = u-coordinate
//   din             operand word, din[7:0] lowest-addressed byte
//   start           launch request
//   start_err       pulse: start rejected (an operand not loaded)
//   busy            multiplier running
//   done            pulse: multiplier finished
//   mult_en         pulse: launch multiplier
//   mult_e          stored (clamped) scalar
//   mult_work_in    stored (masked) u-coordinate
//   mult_out_valid  multiplier result valid
module x25519_operand_loader #(
  parameter bit CLAMP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         din_sel,
  input  logic [31:0]  din,
  input  logic         start,
  output logic         start_err,
  output logic         busy,
  output logic         done,
  output logic         mult_en,
  output logic [255:0] mult_e,
  output logic [255:0] mult_work_in,
  input  logic         mult_out_valid
);

  import x25519_pkg::*;

  loader_state_t  state;
  logic [2:0]     e_cnt;
  logic [2:0]     u_cnt;
  logic           e_loaded;
  logic           u_loaded;

  logic           word_fire;
  logic [255:0]   e_wr;
  logic [255:0]   u_wr;

  // Candidate next operand values: the incoming word merged at the current
  // counter position, with clamp/mask folded in when it is the last word.
  // A loaded operand always has its counter back at 0, so a rewrite
  // naturally lands at word 0.
  always_comb begin
    word_fire = din_valid && din_ready;

    e_wr = mult_e;
    e_wr[32*e_cnt +: 32] = din;
    if (CLAMP && (e_cnt == 3'd7)) begin
      e_wr = x25519_clamp_scalar(e_wr);
    end

    u_wr = mult_work_in;
    u_wr[32*u_cnt +: 32] = din;
    if (CLAMP && (u_cnt == 3'd7)) begin
      u_wr = x25519_mask_u(u_wr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      din_ready    <= 1'b1;
      start_err    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mult_en      <= 1'b0;
      mult_e       <= '0;
      mult_work_in <= '0;
      e_cnt        <= '0;
      u_cnt        <= '0;
      e_loaded     <= 1'b0;
      u_loaded     <= 1'b0;
    end else begin
      mult_en   <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;

      // Word intake; din_ready is only high in IDLE.
      if (word_fire) begin
        if (!din_sel) begin
          mult_e   <= e_wr;
          e_cnt    <= e_cnt + 3'd1;
          e_loaded <= (e_cnt == 3'd7);
        end else begin
          mult_work_in <= u_wr;
          u_cnt        <= u_cnt + 3'd1;
          u_loaded     <= (u_cnt == 3'd7);
        end
      end

      // Start decisions use the flags as registered before this cycle's
      // word, so a final word arriving with start is accepted but the
      // start is rejected.
      unique case (state)
        IDLE: begin
          if (start) begin
            if (e_loaded && u_loaded) begin
              state     <= RUN;
              mult_en   <= 1'b1;
              busy      <= 1'b1;
              din_ready <= 1'b0;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mult_out_valid) begin
            state     <= IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            din_ready <= 1'b1;
            e_loaded  <= 1'b0;
            u_loaded  <= 1'b0;
            e_cnt     <= '0;
            u_cnt     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
